// File: rtl/ascon_pkg.sv
// Shared types, constants and the single-round function for the Ascon-128
// decrypt datapath and its p^b permutation core.
package ascon_pkg;

  typedef logic [63:0]      word_t;
  typedef logic [4:0][63:0] ascon_state_t;

  localparam word_t       DOMAIN_SEP = 64'h1;
  localparam int unsigned RATE_IDX   = 0;

  typedef enum logic [2:0] {
    IDLE,
    AD0_WAIT,
    AD1_WAIT,
    CT0,
    CT0_WAIT,
    DONE
  } dec_state_e;

  function automatic word_t ror64(input word_t x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One Ascon round: constant addition, bitsliced 5-bit S-box, linear diffusion.
  function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [7:0] rc);
    word_t x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'h0, rc};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1) ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7) ^ ror64(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

endpackage

// File: rtl/ascon_permutation.sv
// Ascon p^b core, one round per clock. done_o pulses ROUNDS_B edges after the
// edge that samples start_i; state_o holds the result until the next start.
module ascon_permutation
  import ascon_pkg::*;
#(
  parameter int ROUNDS_B = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  ascon_state_t state_i,
  output ascon_state_t state_o,
  output logic         done_o
);

  // p^b uses the last b of the twelve round constants.
  localparam logic [3:0] FIRST_RND = 4'(12 - ROUNDS_B);
  localparam logic [3:0] LAST_CNT  = 4'(ROUNDS_B - 1);

  logic         busy_q, busy_d;
  logic [3:0]   cnt_q, cnt_d;
  ascon_state_t st_q, st_d;
  logic         done_q, done_d;
  logic [3:0]   rnd;
  logic [7:0]   rc;

  assign rnd = FIRST_RND + cnt_q;
  assign rc  = {4'hf - rnd, rnd};

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    st_d   = st_q;
    done_d = 1'b0;
    if (busy_q) begin
      st_d  = ascon_round(st_q, rc);
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == LAST_CNT) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start_i) begin
      st_d   = state_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      st_q   <= '0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      done_q <= done_d;
    end
  end

  assign state_o = st_q;
  assign done_o  = done_q;

endmodule

// File: rtl/ascon_decrypt.sv
// Ascon-128 decrypt data phase: absorbs A0/A1, applies domain separation, then
// decrypts C0/C1 and returns the pre-finalization state for tag generation.
module ascon_decrypt
  import ascon_pkg::*;
#(
  parameter int ROUNDS_B = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  ascon_state_t     state_in,
  input  logic [1:0][63:0] associated_data,
  input  logic [1:0][63:0] ciphertext,
  output logic [1:0][63:0] plaintext,
  output ascon_state_t     state_out,
  output logic             done
);

  // start is a level request honoured only in IDLE; done is a one-cycle pulse.
  // perm_start/perm_done are single-cycle pulses: one launch, one completion.
  dec_state_e       fsm_q, fsm_d;
  ascon_state_t     s_q, s_d, sout_q, sout_d, perm_state;
  logic [1:0][63:0] pt_q, pt_d;
  logic             done_q, done_d;
  logic             perm_start_q, perm_start_d, perm_done;

  ascon_permutation #(.ROUNDS_B(ROUNDS_B)) u_perm (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(perm_start_q),
    .state_i(s_q),
    .state_o(perm_state),
    .done_o (perm_done)
  );

  always_comb begin
    fsm_d        = fsm_q;
    s_d          = s_q;
    pt_d         = pt_q;
    sout_d       = sout_q;
    done_d       = 1'b0;
    perm_start_d = 1'b0;
    case (fsm_q)
      IDLE: if (start) begin
        s_d           = state_in;
        s_d[RATE_IDX] = state_in[RATE_IDX] ^ associated_data[0];
        perm_start_d  = 1'b1;
        fsm_d         = AD0_WAIT;
      end
      AD0_WAIT: if (perm_done) begin
        s_d           = perm_state;
        s_d[RATE_IDX] = perm_state[RATE_IDX] ^ associated_data[1];
        perm_start_d  = 1'b1;
        fsm_d         = AD1_WAIT;
      end
      AD1_WAIT: if (perm_done) begin
        s_d    = perm_state;
        s_d[4] = perm_state[4] ^ DOMAIN_SEP;
        fsm_d  = CT0;
      end
      CT0: begin
        pt_d[0]       = ciphertext[0] ^ s_q[RATE_IDX];
        s_d[RATE_IDX] = ciphertext[0];
        perm_start_d  = 1'b1;
        fsm_d         = CT0_WAIT;
      end
      // Last block: no permutation follows, finalization takes over the state.
      CT0_WAIT: if (perm_done) begin
        pt_d[1]       = ciphertext[1] ^ perm_state[RATE_IDX];
        s_d           = perm_state;
        s_d[RATE_IDX] = ciphertext[1];
        fsm_d         = DONE;
      end
      DONE: begin
        sout_d = s_q;
        done_d = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= IDLE;
      s_q          <= '0;
      pt_q         <= '0;
      sout_q       <= '0;
      done_q       <= 1'b0;
      perm_start_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      s_q          <= s_d;
      pt_q         <= pt_d;
      sout_q       <= sout_d;
      done_q       <= done_d;
      perm_start_q <= perm_start_d;
    end
  end

  assign plaintext = pt_q;
  assign state_out = sout_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ascon_decrypt.sv
// Bench for ascon_decrypt: an Ascon reference model (table S-box) encrypts
// random data, the DUT decrypts it, and every done pulse is scored.
module tb_ascon_decrypt;

  typedef logic [4:0][63:0] st_t;
  typedef logic [1:0][63:0] w2_t;

  localparam int ROUNDS_B = 6;
  localparam int L        = ROUNDS_B;
  localparam int DONE_LAT = 3 * L + 8;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [7:0] RC [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                     8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  logic clk, rst_n, start, done;
  st_t  state_in, state_out;
  w2_t  associated_data, ciphertext, plaintext;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [447:0] exp_q[$];
  int           exp_cyc_q[$];

  logic ps_prev   = 1'b0;
  int   ps_pulses = 0;
  int   ps_wide   = 0;

  ascon_decrypt #(.ROUNDS_B(ROUNDS_B)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .state_in       (state_in),
    .associated_data(associated_data),
    .ciphertext     (ciphertext),
    .plaintext      (plaintext),
    .state_out      (state_out),
    .done           (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    errors = errors + 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic st_t perm_model(input st_t s, input int nr);
    st_t x;
    logic [4:0] col, o;
    x = s;
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] = x[2] ^ {56'h0, RC[r]};
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = SBOX[col];
        x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
      end
      for (int i = 0; i < 5; i++) x[i] = x[i] ^ rotr(x[i], ROT_A[i]) ^ rotr(x[i], ROT_B[i]);
    end
    return x;
  endfunction

  function automatic void enc_model(input st_t si, input w2_t a, input w2_t p,
                                    output w2_t c, output st_t so);
    st_t s;
    s = si;
    s[0] = s[0] ^ a[0];  s = perm_model(s, ROUNDS_B);
    s[0] = s[0] ^ a[1];  s = perm_model(s, ROUNDS_B);
    s[4] = s[4] ^ 64'h1;
    c[0] = p[0] ^ s[0];  s[0] = c[0];  s = perm_model(s, ROUNDS_B);
    c[1] = p[1] ^ s[0];  s[0] = c[1];
    so = s;
  endfunction

  function automatic void dec_model(input st_t si, input w2_t a, input w2_t c,
                                    output w2_t p, output st_t so);
    st_t s;
    s = si;
    s[0] = s[0] ^ a[0];  s = perm_model(s, ROUNDS_B);
    s[0] = s[0] ^ a[1];  s = perm_model(s, ROUNDS_B);
    s[4] = s[4] ^ 64'h1;
    p[0] = c[0] ^ s[0];  s[0] = c[0];  s = perm_model(s, ROUNDS_B);
    p[1] = c[1] ^ s[0];  s[0] = c[1];
    so = s;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic st_t rand_st();
    st_t s;
    for (int i = 0; i < 5; i++) s[i] = rand64();
    return s;
  endfunction

  // ---------------- check helpers ----------------
  task automatic check_vec(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        logic [447:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check_vec("plaintext", {192'h0, plaintext}, {192'h0, e[447:320]});
        check_vec("state_out", state_out, e[319:0]);
        check_int("done_cycle", cyc, ec);
      end
    end
  end

  always @(negedge clk) begin
    ps_prev <= dut.perm_start_q;
    if (dut.perm_start_q && !ps_prev) ps_pulses <= ps_pulses + 1;
    if (dut.perm_start_q && ps_prev) ps_wide <= ps_wide + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input st_t s, input w2_t a, input w2_t c,
                          input w2_t ep, input st_t es, input bit hold);
    @(negedge clk);
    state_in        = s;
    associated_data = a;
    ciphertext      = c;
    start           = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({ep, es});
    exp_cyc_q.push_back(cyc + DONE_LAT);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4 * DONE_LAT && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL done_timeout: got %0d pending ops expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    st_t s, so, z, r1;
    w2_t a, p, c;
    int  base;

    rst_n = 1'b0;
    start = 1'b0;
    state_in = '0;
    associated_data = '0;
    ciphertext = '0;
    repeat (2) @(negedge clk);
    check_vec("reset_plaintext", {192'h0, plaintext}, 320'h0);
    check_vec("reset_state_out", state_out, 320'h0);
    check_int("reset_done", int'(done), 0);
    check_int("reset_perm_start", int'(dut.perm_start_q), 0);
    rst_n = 1'b1;

    // Hand-derived pins on the model: one round (constant 0x4b) of the zero state.
    z = '0;
    r1 = perm_model(z, 1);
    check_vec("model_round_x0", {256'h0, r1[0]}, {256'h0, 64'h000964B00000004B});
    check_vec("model_round_x1", {256'h0, r1[1]}, {256'h0, 64'h0000000096000213});
    check_vec("model_rotr", {256'h0, rotr(64'h1, 1)}, {256'h0, 64'h8000000000000000});

    // Known answer: key = nonce = AD = 00..0F, plaintext 00..0F.
    s[0] = 64'h80400c0600000000;
    s[1] = 64'h0001020304050607;
    s[2] = 64'h08090a0b0c0d0e0f;
    s[3] = 64'h0001020304050607;
    s[4] = 64'h08090a0b0c0d0e0f;
    s = perm_model(s, 12);
    s[3] = s[3] ^ 64'h0001020304050607;
    s[4] = s[4] ^ 64'h08090a0b0c0d0e0f;
    a[0] = 64'h0001020304050607;
    a[1] = 64'h08090a0b0c0d0e0f;
    p = a;
    enc_model(s, a, p, c, so);
    start_op(s, a, c, {64'h08090a0b0c0d0e0f, 64'h0001020304050607}, so, 1'b0);
    wait_drain();

    // All-zero operands: exactly three single-cycle permutation launches.
    base = ps_pulses;
    dec_model('0, '0, '0, p, so);
    start_op('0, '0, '0, p, so, 1'b0);
    wait_drain();
    check_int("perm_start_pulses", ps_pulses - base, 3);

    // start re-pulsed while in AD1_WAIT is ignored.
    s = rand_st(); a = {rand64(), rand64()}; p = {rand64(), rand64()};
    enc_model(s, a, p, c, so);
    start_op(s, a, c, p, so, 1'b0);
    repeat (L + 5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // start held high across two back-to-back operations with different C.
    s = rand_st(); a = {rand64(), rand64()}; p = {rand64(), rand64()};
    enc_model(s, a, p, c, so);
    start_op(s, a, c, p, so, 1'b1);
    repeat (DONE_LAT) @(negedge clk);
    p = {rand64(), rand64()};
    enc_model(s, a, p, c, so);
    start_op(s, a, c, p, so, 1'b0);
    wait_drain();

    // Reset in CT0_WAIT: outputs clear at once and the op never completes.
    s = rand_st(); a = {rand64(), rand64()}; p = {rand64(), rand64()};
    enc_model(s, a, p, c, so);
    start_op(s, a, c, p, so, 1'b0);
    repeat (2 * L + 9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_vec("midrst_plaintext", {192'h0, plaintext}, 320'h0);
    check_vec("midrst_state_out", state_out, 320'h0);
    check_int("midrst_done", int'(done), 0);
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * DONE_LAT) @(negedge clk);
    start_op(s, a, c, p, so, 1'b0);
    wait_drain();

    // Randomized round trips through the encryption model.
    for (int it = 0; it < 1000; it++) begin
      s = rand_st(); a = {rand64(), rand64()}; p = {rand64(), rand64()};
      enc_model(s, a, p, c, so);
      start_op(s, a, c, p, so, 1'b0);
      wait_drain();
    end

    repeat (3) @(negedge clk);
    check_int("perm_start_width", ps_wide, 0);
    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
